// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the UART transmit path
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

  localparam int MAX_REQ = 8;

  function automatic byte_t sat_inc8(input byte_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority search starting after ptr
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         gnt_idx,
  output logic               gnt_any
);

  int w_dist;
  int w_best;

  // Distance of j from ptr+1 going upward modulo NUM_REQ; the nearest asserted request wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = (j - int'(ptr) - 1 + 8 * MAX_REQ) % NUM_REQ;
      if (req[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = 3'(j);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-level round-robin arbiter feeding the output FIFO
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] s_data,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ-1:0]   s_last,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic [7:0]           fifo_dout,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           timeout_count
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t      r_state;
  logic [2:0]      r_rr_ptr;
  logic [2:0]      r_grant_id;
  logic            r_busy;
  byte_t           r_to_cnt;
  logic [WD_W-1:0] r_wdog;

  logic            w_valid_g;
  logic            w_last_g;
  byte_t           w_data_g;
  logic            w_xfer;
  logic            w_beat;
  logic [2:0]      w_arb_idx;
  logic            w_arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (s_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .gnt_any (w_arb_any)
  );

  assign w_xfer = (r_state == ARB_XFER);

  always_comb begin
    w_valid_g = 1'b0;
    w_last_g  = 1'b0;
    w_data_g  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_valid_g = s_valid[i];
        w_last_g  = s_last[i];
        w_data_g  = s_data[i*8 +: 8];
      end
    end
  end

  // Zero-latency pass-through: only the granted requester sees ready, gated by FIFO space.
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_ready[i] = w_xfer && (r_grant_id == 3'(i)) && !fifo_full;
    end
  end

  assign w_beat        = w_xfer && w_valid_g && !fifo_full;
  assign fifo_wr_en    = w_beat;
  assign fifo_dout     = w_beat ? w_data_g : '0;
  assign grant_id      = r_grant_id;
  assign busy          = r_busy;
  assign timeout_count = r_to_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= 3'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_to_cnt   <= '0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_arb_any) begin
            r_grant_id <= w_arb_idx;
            r_state    <= ARB_XFER;
            r_busy     <= 1'b1;
            r_wdog     <= '0;
          end
        end
        ARB_XFER: begin
          if (w_beat) begin
            r_wdog <= '0;
            if (w_last_g) begin
              r_rr_ptr <= r_grant_id;
              r_state  <= ARB_IDLE;
              r_busy   <= 1'b0;
            end
          end else if (!w_valid_g && (TIMEOUT_CYCLES > 0)) begin
            // A stalled producer loses its grant; its remaining bytes re-arbitrate as a new frame.
            if (r_wdog == WD_LAST) begin
              r_rr_ptr <= r_grant_id;
              r_state  <= ARB_IDLE;
              r_busy   <= 1'b0;
              r_to_cnt <= sat_inc8(r_to_cnt);
            end else begin
              r_wdog <= r_wdog + WD_W'(1);
            end
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 2;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  s_data;
  logic [1:0]   s_valid;
  logic [1:0]   s_last;
  logic [1:0]   s_ready;
  logic [7:0]   fifo_dout;
  logic         fifo_wr_en;
  logic         fifo_full;
  logic [2:0]   grant_id;
  logic         busy;
  logic [7:0]   timeout_count;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .fifo_dout     (fifo_dout),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Producer queues: bit 8 marks the last byte of a frame.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [1:0] hs;

  always @(posedge clk) begin
    #2;
    if (hs[0] && q0.size() > 0) void'(q0.pop_front());
    if (hs[1] && q1.size() > 0) void'(q1.pop_front());
    s_valid[0]   = (q0.size() > 0);
    s_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    s_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
    s_valid[1]   = (q1.size() > 0);
    s_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    s_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
  end

  typedef struct {
    int cyc;
    int src;
    int data;
  } wr_t;

  wr_t wlog[$];
  int  cyc      = 0;
  int  busy_cnt = 0;

  // Reference model: who owns the FIFO, how long it has been silent, whose turn is next.
  int  m_owner = -1;
  int  m_ptr   = N - 1;
  int  m_idle  = 0;
  int  m_gid   = 0;
  int  m_tocnt = 0;
  bit  m_on    = 0;

  always @(negedge clk) begin
    int e_wr, e_dout, e_rdy, ov, ol, k;
    cyc++;
    hs = s_valid & s_ready;
    if (fifo_wr_en) wlog.push_back('{cyc, int'(grant_id), int'(fifo_dout)});
    if (busy) busy_cnt++;
    ov = (m_owner >= 0) ? int'((s_valid >> m_owner) & 2'b01) : 0;
    ol = (m_owner >= 0) ? int'((s_last >> m_owner) & 2'b01) : 0;
    e_wr   = (ov == 1 && !fifo_full) ? 1 : 0;
    e_dout = (e_wr == 1) ? int'((s_data >> (8 * m_owner)) & 16'h00FF) : 0;
    e_rdy  = (m_owner >= 0 && !fifo_full) ? (1 << m_owner) : 0;
    if (m_on) begin
      check("wr_en", int'(fifo_wr_en), e_wr);
      check("dout", int'(fifo_dout), e_dout);
      check("ready", int'(s_ready), e_rdy);
      check("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
      check("grant_id", int'(grant_id), m_gid);
      check("timeout_count", int'(timeout_count), m_tocnt);
    end
    if (!rst) begin
      m_on = 1; m_owner = -1; m_ptr = N - 1; m_idle = 0; m_gid = 0; m_tocnt = 0;
    end else if (m_on) begin
      if (m_owner < 0) begin
        for (int s = 1; s <= N; s++) begin
          k = (m_ptr + s) % N;
          if (((s_valid >> k) & 2'b01) != 0 && m_owner < 0) begin
            m_owner = k; m_gid = k; m_idle = 0;
          end
        end
      end else if (e_wr == 1) begin
        m_idle = 0;
        if (ol == 1) begin m_ptr = m_owner; m_owner = -1; end
      end else if (ov == 0) begin
        m_idle++;
        if (m_idle == T) begin
          m_ptr = m_owner; m_owner = -1;
          if (m_tocnt < 255) m_tocnt++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    step(1);
    while ((q0.size() != 0 || q1.size() != 0 || busy || s_valid != 2'b00) && n < maxc) begin
      step(1);
      n++;
    end
    if (n >= maxc) begin
      total++;
      bad++;
      $display("FAIL %s cycle budget %0d exhausted", name, maxc);
    end
    step(2);
  endtask

  initial begin
    rst = 1'b0; fifo_full = 1'b0; s_valid = '0; s_last = '0; s_data = '0; hs = '0;
    step(3);
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_tocnt", int'(timeout_count), 0);
    check("rst_ready", int'(s_ready), 0);
    check("rst_wr_en", int'(fifo_wr_en), 0);
    check("rst_dout", int'(fifo_dout), 0);
    step(1);
    rst = 1'b1;

    // Single 3-byte frame from requester 0
    wlog.delete(); busy_cnt = 0;
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h143);
    drain("single_drain", 50);
    check("single_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("single_b0", wlog[0].data, 8'h41);
      check("single_b1", wlog[1].data, 8'h42);
      check("single_b2", wlog[2].data, 8'h43);
    end
    check("single_busy_cycles", busy_cnt, 3);
    check("single_grant", int'(grant_id), 0);

    // Contention from reset: req0 twice, req1 once
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    wlog.delete();
    q0.push_back(9'h0A0); q0.push_back(9'h1A1); q0.push_back(9'h0A2); q0.push_back(9'h1A3);
    q1.push_back(9'h0B0); q1.push_back(9'h1B1);
    drain("cont_drain", 80);
    check("cont_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      check("cont_d0", wlog[0].data, 8'hA0); check("cont_s0", wlog[0].src, 0);
      check("cont_d1", wlog[1].data, 8'hA1); check("cont_s1", wlog[1].src, 0);
      check("cont_d2", wlog[2].data, 8'hB0); check("cont_s2", wlog[2].src, 1);
      check("cont_d3", wlog[3].data, 8'hB1); check("cont_s3", wlog[3].src, 1);
      check("cont_d4", wlog[4].data, 8'hA2); check("cont_s4", wlog[4].src, 0);
      check("cont_d5", wlog[5].data, 8'hA3); check("cont_s5", wlog[5].src, 0);
      check("cont_gap01", wlog[1].cyc - wlog[0].cyc, 1);
      check("cont_gap12", wlog[2].cyc - wlog[1].cyc, 2);
      check("cont_gap23", wlog[3].cyc - wlog[2].cyc, 1);
      check("cont_gap34", wlog[4].cyc - wlog[3].cyc, 2);
    end

    // Backpressure: 10 full cycles in the middle of a 4-byte frame
    wlog.delete();
    q0.push_back(9'h050); q0.push_back(9'h051); q0.push_back(9'h052); q0.push_back(9'h153);
    for (int i = 0; i < 40 && wlog.size() < 2; i++) step(1);
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #3;
      check("bp_wr_en", int'(fifo_wr_en), 0);
      check("bp_ready", int'(s_ready), 0);
      check("bp_busy", int'(busy), 1);
      step(1);
    end
    fifo_full = 1'b0;
    drain("bp_drain", 50);
    check("bp_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      check("bp_b0", wlog[0].data, 8'h50);
      check("bp_b1", wlog[1].data, 8'h51);
      check("bp_b2", wlog[2].data, 8'h52);
      check("bp_b3", wlog[3].data, 8'h53);
    end
    check("bp_tocnt", int'(timeout_count), 0);

    // Watchdog: req1 stalls after one byte, req0 waits
    wlog.delete();
    q1.push_back(9'h060);
    step(2);
    q0.push_back(9'h071); q0.push_back(9'h172);
    drain("wd_drain", 80);
    check("wd_tocnt", int'(timeout_count), 1);
    check("wd_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("wd_d0", wlog[0].data, 8'h60); check("wd_s0", wlog[0].src, 1);
      check("wd_d1", wlog[1].data, 8'h71); check("wd_s1", wlog[1].src, 0);
      check("wd_d2", wlog[2].data, 8'h72);
      check("wd_gap", wlog[1].cyc - wlog[0].cyc, 18);
    end

    // Reset in the middle of a 5-byte frame
    wlog.delete();
    q0.push_back(9'h080); q0.push_back(9'h081); q0.push_back(9'h082);
    q0.push_back(9'h083); q0.push_back(9'h184);
    for (int i = 0; i < 40 && wlog.size() < 2; i++) step(1);
    rst = 1'b0;
    q0.delete(); q1.delete();
    step(1);
    #3;
    check("mrst_ready", int'(s_ready), 0);
    check("mrst_wr_en", int'(fifo_wr_en), 0);
    check("mrst_dout", int'(fifo_dout), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_grant", int'(grant_id), 0);
    check("mrst_tocnt", int'(timeout_count), 0);
    rst = 1'b1;
    step(1);
    wlog.delete();
    q0.push_back(9'h1C0);
    q1.push_back(9'h190);
    drain("mrst_drain", 50);
    check("mrst_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("mrst_d0", wlog[0].data, 8'hC0); check("mrst_s0", wlog[0].src, 0);
      check("mrst_d1", wlog[1].data, 8'h90); check("mrst_s1", wlog[1].src, 1);
    end

    // Saturation of the revoked-grant counter
    for (int i = 0; i < 260; i++) begin
      q0.push_back(9'h001);
      drain("sat_drain", 60);
    end
    check("sat_tocnt", int'(timeout_count), 255);
    wlog.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
